// File: rtl/legv8_multicycle_control_if.sv
// Control/datapath bundle for the multicycle LEGv8 core.
// master = control FSM, slave = datapath.
interface legv8_multicycle_control_if;
   logic [10:0] opcode;
   logic        zero;
   logic        mem_ready;
   logic [1:0]  alu_op;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic        iord;
   logic        mem_read;
   logic        mem_write;
   logic        ir_write;
   logic        reg2loc;
   logic        reg_write;
   logic        mem_to_reg;
   logic        pc_src;
   logic        pc_en;
   logic        retired;
   logic        illegal;

   modport master (
      input  opcode, zero, mem_ready,
      output alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
             reg2loc, reg_write, mem_to_reg, pc_src, pc_en, retired, illegal
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
             reg2loc, reg_write, mem_to_reg, pc_src, pc_en, retired, illegal
   );
endinterface

// File: rtl/legv8_multicycle_control.sv
// Main control FSM of the multicycle LEGv8 core: sequences the shared ALU,
// unified memory and register file, waits on mem_ready, traps on bad opcodes.
module legv8_multicycle_control (
   input  logic                              clk,
   input  logic                              reset,
   legv8_multicycle_control_if.master        bus
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_MEM_ADDR, S_MEM_READ,
      S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_TRAP
   } state_t;

   typedef enum logic [2:0] {C_ILL, C_R, C_LDUR, C_STUR, C_CBZ, C_B} cls_t;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg2loc;
      logic       reg_write;
      logic       mem_to_reg;
      logic       pc_src;
      logic       pc_en;
      logic       retired;
      logic       illegal;
   } ctrl_t;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;

   state_t state, nxt;
   cls_t   dec_cls, cls_q;
   ctrl_t  c, o;

   always_comb begin
      dec_cls = C_ILL;
      if (bus.opcode == OP_ADD || bus.opcode == OP_SUB ||
          bus.opcode == OP_AND || bus.opcode == OP_ORR) dec_cls = C_R;
      else if (bus.opcode == OP_LDUR)                   dec_cls = C_LDUR;
      else if (bus.opcode == OP_STUR)                   dec_cls = C_STUR;
      else if (bus.opcode[10:3] == 8'b10110100)         dec_cls = C_CBZ;
      else if (bus.opcode[10:5] == 6'b000101)           dec_cls = C_B;
   end

   // The class is captured once at the end of DECODE; later opcode changes are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
         cls_q <= C_ILL;
      end else begin
         state <= nxt;
         if (state == S_DECODE) cls_q <= dec_cls;
      end
   end

   always_comb begin
      nxt = state;
      c   = '0;
      case (state)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
            if (bus.mem_ready) begin
               c.ir_write = 1'b1;
               c.pc_en    = 1'b1;
               nxt        = S_DECODE;
            end
         end
         S_DECODE: begin
            c.alu_src_b = 2'b11;
            c.reg2loc   = (dec_cls == C_STUR) || (dec_cls == C_CBZ);
            case (dec_cls)
               C_R:           nxt = S_EXEC_R;
               C_LDUR, C_STUR: nxt = S_MEM_ADDR;
               C_CBZ:         nxt = S_BRANCH;
               C_B:           nxt = S_JUMP;
               default:       nxt = S_TRAP;
            endcase
         end
         S_EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
            nxt         = S_R_WB;
         end
         S_R_WB: begin
            c.reg_write = 1'b1;
            c.retired   = 1'b1;
            nxt         = S_FETCH;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.reg2loc   = (cls_q == C_STUR);
            nxt         = (cls_q == C_STUR) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
            if (bus.mem_ready) nxt = S_MEM_WB;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.retired    = 1'b1;
            nxt          = S_FETCH;
         end
         S_MEM_WRITE: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
            c.reg2loc   = 1'b1;
            if (bus.mem_ready) begin
               c.retired = 1'b1;
               nxt       = S_FETCH;
            end
         end
         S_BRANCH: begin
            c.alu_src_a = 1'b1;
            c.reg2loc   = 1'b1;
            c.alu_op    = 2'b01;
            c.pc_src    = 1'b1;
            c.pc_en     = bus.zero;
            c.retired   = 1'b1;
            nxt         = S_FETCH;
         end
         S_JUMP: begin
            c.pc_src  = 1'b1;
            c.pc_en   = 1'b1;
            c.retired = 1'b1;
            nxt       = S_FETCH;
         end
         S_TRAP:  c.illegal = 1'b1;
         default: nxt = S_FETCH;
      endcase
   end

   // Reset masks every output in the same cycle, so nothing leaks while it is held.
   assign o = reset ? '0 : c;

   assign bus.alu_op     = o.alu_op;
   assign bus.alu_src_a  = o.alu_src_a;
   assign bus.alu_src_b  = o.alu_src_b;
   assign bus.iord       = o.iord;
   assign bus.mem_read   = o.mem_read;
   assign bus.mem_write  = o.mem_write;
   assign bus.ir_write   = o.ir_write;
   assign bus.reg2loc    = o.reg2loc;
   assign bus.reg_write  = o.reg_write;
   assign bus.mem_to_reg = o.mem_to_reg;
   assign bus.pc_src     = o.pc_src;
   assign bus.pc_en      = o.pc_en;
   assign bus.retired    = o.retired;
   assign bus.illegal    = o.illegal;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Bench for legv8_multicycle_control: table vectors, hand sequences and random
// instruction streams checked cycle by cycle against a step-list model.
module tb_legv8_multicycle_control;

   typedef enum int {P_FETCH, P_DEC, P_EXR, P_RWB, P_MADDR, P_MRD, P_MWB,
                     P_MWR, P_BR, P_JMP, P_TRAP, P_RST} phase_t;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       a;
      logic [1:0] b;
      logic       iord, mrd, mwr, irw, r2l, rw, m2r, pcs, pce, ret, ill;
   } outs_t;

   typedef struct {
      string       name;
      logic [10:0] op;
      logic        zero;
      int          wf;
      int          wm;
      int          lat;
      bit          ill;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   phase_t ph_q[$];
   bit     mr_q[$];
   int     ret_cnt, ret_at;
   bit     last_ret;

   legv8_multicycle_control_if bus ();

   legv8_multicycle_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // 0 illegal, 1 R-type, 2 LDUR, 3 STUR, 4 CBZ, 5 B
   function automatic int classify(logic [10:0] op);
      if (op == 11'b10001011000 || op == 11'b11001011000 ||
          op == 11'b10001010000 || op == 11'b10101010000) return 1;
      if (op == 11'b11111000010) return 2;
      if (op == 11'b11111000000) return 3;
      if (op[10:3] == 8'b10110100) return 4;
      if (op[10:5] == 6'b000101) return 5;
      return 0;
   endfunction

   function automatic outs_t exp_out(phase_t p, int cls, logic z, logic mr);
      outs_t e = '0;
      case (p)
         P_FETCH: begin e.mrd = 1; e.b = 2'b01; e.irw = mr; e.pce = mr; end
         P_DEC:   begin e.b = 2'b11; e.r2l = (cls == 3 || cls == 4); end
         P_EXR:   begin e.a = 1; e.alu_op = 2'b10; end
         P_RWB:   begin e.rw = 1; e.ret = 1; end
         P_MADDR: begin e.a = 1; e.b = 2'b10; e.r2l = (cls == 3); end
         P_MRD:   begin e.mrd = 1; e.iord = 1; end
         P_MWB:   begin e.rw = 1; e.m2r = 1; e.ret = 1; end
         P_MWR:   begin e.mwr = 1; e.iord = 1; e.r2l = 1; e.ret = mr; end
         P_BR:    begin e.a = 1; e.r2l = 1; e.alu_op = 2'b01; e.pcs = 1; e.pce = z; e.ret = 1; end
         P_JMP:   begin e.pcs = 1; e.pce = 1; e.ret = 1; end
         P_TRAP:  e.ill = 1;
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic int base_lat(int cls);
      case (cls)
         1: return 4;
         2: return 5;
         3: return 4;
         default: return 3;
      endcase
   endfunction

   task automatic drive_check(phase_t p, int cls, logic [10:0] opd, logic z, logic mr, logic rst);
      outs_t act, exp;
      bus.opcode = opd;
      bus.zero = z;
      bus.mem_ready = mr;
      reset = rst;
      @(negedge clk);
      act = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.iord, bus.mem_read,
             bus.mem_write, bus.ir_write, bus.reg2loc, bus.reg_write,
             bus.mem_to_reg, bus.pc_src, bus.pc_en, bus.retired, bus.illegal};
      exp = exp_out(p, cls, z, mr);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL cycle phase=%0d mr=%0b zero=%0b act=%h exp=%h", p, mr, z, act, exp);
      end
      last_ret = act.ret;
      @(posedge clk);
      #1;
   endtask

   function automatic bit rnd();
      return 1'($urandom);
   endfunction

   // Expand one instruction into the steps the spec prescribes, with wait cycles.
   task automatic build_q(int cls, int wf, int wm);
      ph_q.delete();
      mr_q.delete();
      for (int i = 0; i < wf; i++) begin ph_q.push_back(P_FETCH); mr_q.push_back(0); end
      ph_q.push_back(P_FETCH); mr_q.push_back(1);
      ph_q.push_back(P_DEC);   mr_q.push_back(rnd());
      case (cls)
         1: begin
            ph_q.push_back(P_EXR); mr_q.push_back(rnd());
            ph_q.push_back(P_RWB); mr_q.push_back(rnd());
         end
         2: begin
            ph_q.push_back(P_MADDR); mr_q.push_back(rnd());
            for (int i = 0; i < wm; i++) begin ph_q.push_back(P_MRD); mr_q.push_back(0); end
            ph_q.push_back(P_MRD); mr_q.push_back(1);
            ph_q.push_back(P_MWB); mr_q.push_back(rnd());
         end
         3: begin
            ph_q.push_back(P_MADDR); mr_q.push_back(rnd());
            for (int i = 0; i < wm; i++) begin ph_q.push_back(P_MWR); mr_q.push_back(0); end
            ph_q.push_back(P_MWR); mr_q.push_back(1);
         end
         4: begin ph_q.push_back(P_BR); mr_q.push_back(rnd()); end
         5: begin ph_q.push_back(P_JMP); mr_q.push_back(rnd()); end
         default: begin
            for (int i = 0; i < 20; i++) begin ph_q.push_back(P_TRAP); mr_q.push_back(rnd()); end
            ph_q.push_back(P_RST); mr_q.push_back(0);
         end
      endcase
   endtask

   task automatic exec_q(logic [10:0] op, logic z);
      int cls = classify(op);
      ret_cnt = 0;
      ret_at = 0;
      for (int i = 0; i < ph_q.size(); i++) begin
         phase_t p = ph_q[i];
         logic [10:0] opd = (p == P_DEC) ? op : 11'($urandom);
         logic zz = (p == P_BR) ? z : rnd();
         drive_check(p, cls, opd, zz, mr_q[i], p == P_RST);
         if (last_ret) begin
            ret_cnt++;
            if (ret_at == 0) ret_at = i + 1;
         end
      end
   endtask

   task automatic run_instr(string name, logic [10:0] op, logic z, int wf, int wm, int lat);
      int cls = classify(op);
      build_q(cls, wf, wm);
      exec_q(op, z);
      tests++;
      if (cls == 0) begin
         if (ret_cnt != 0) begin
            fails++;
            $display("FAIL %s retired_in_trap act=%0d exp=0", name, ret_cnt);
         end
      end else if (ret_cnt != 1 || ret_at != lat) begin
         fails++;
         $display("FAIL %s latency act=%0d pulses=%0d exp=%0d pulses=1", name, ret_at, ret_cnt, lat);
      end
   endtask

   vec_t vt[$];

   initial begin
      vt.push_back('{"add",     11'b10001011000, 1'b0, 0, 0, 4, 1'b0});
      vt.push_back('{"sub",     11'b11001011000, 1'b1, 0, 0, 4, 1'b0});
      vt.push_back('{"and",     11'b10001010000, 1'b0, 1, 0, 5, 1'b0});
      vt.push_back('{"orr",     11'b10101010000, 1'b0, 0, 0, 4, 1'b0});
      vt.push_back('{"ldur",    11'b11111000010, 1'b0, 0, 0, 5, 1'b0});
      vt.push_back('{"ldur_w3", 11'b11111000010, 1'b0, 0, 3, 8, 1'b0});
      vt.push_back('{"cbz_z1",  11'b10110100101, 1'b1, 0, 0, 3, 1'b0});
      vt.push_back('{"cbz_z0",  11'b10110100011, 1'b0, 0, 0, 3, 1'b0});
      vt.push_back('{"stur",    11'b11111000000, 1'b0, 0, 0, 4, 1'b0});
      vt.push_back('{"b",       11'b00010110011, 1'b0, 0, 0, 3, 1'b0});
      vt.push_back('{"stur_w2", 11'b11111000000, 1'b0, 2, 2, 8, 1'b0});
      vt.push_back('{"ill_ff",  11'b11111111111, 1'b0, 0, 0, 0, 1'b1});
      vt.push_back('{"add_ok",  11'b10001011000, 1'b0, 0, 0, 4, 1'b0});
      vt.push_back('{"ill_add1",11'b10001011001, 1'b0, 0, 0, 0, 1'b1});
      vt.push_back('{"b_ok",    11'b00010100000, 1'b0, 0, 0, 3, 1'b0});

      // Reset state: all outputs low while reset is held.
      drive_check(P_RST, 0, 11'h0, 1'b0, 1'b1, 1'b1);
      drive_check(P_RST, 0, 11'h0, 1'b0, 1'b1, 1'b1);

      foreach (vt[i]) run_instr(vt[i].name, vt[i].op, vt[i].zero, vt[i].wf, vt[i].wm, vt[i].lat);

      // Reset during a stalled store: no write after the edge, restart in FETCH.
      drive_check(P_FETCH, 3, 11'h0, 1'b0, 1'b1, 1'b0);
      drive_check(P_DEC,   3, 11'b11111000000, 1'b0, 1'b0, 1'b0);
      drive_check(P_MADDR, 3, 11'h0, 1'b0, 1'b0, 1'b0);
      drive_check(P_MWR,   3, 11'h0, 1'b0, 1'b0, 1'b0);
      drive_check(P_MWR,   3, 11'h0, 1'b0, 1'b0, 1'b0);
      drive_check(P_RST,   3, 11'h0, 1'b0, 1'b0, 1'b1);
      drive_check(P_RST,   3, 11'h0, 1'b0, 1'b1, 1'b1);
      drive_check(P_FETCH, 0, 11'h0, 1'b0, 1'b0, 1'b0);
      run_instr("post_rst_add", 11'b10001011000, 1'b0, 0, 0, 4);

      // Reset during a stalled load.
      drive_check(P_FETCH, 2, 11'h0, 1'b0, 1'b1, 1'b0);
      drive_check(P_DEC,   2, 11'b11111000010, 1'b0, 1'b0, 1'b0);
      drive_check(P_MADDR, 2, 11'h0, 1'b0, 1'b1, 1'b0);
      drive_check(P_MRD,   2, 11'h0, 1'b0, 1'b0, 1'b0);
      drive_check(P_RST,   2, 11'h0, 1'b0, 1'b1, 1'b1);
      run_instr("post_rst_b", 11'b00010111111, 1'b0, 0, 0, 3);

      // Random legal stream with random waits and junk mem_ready/opcode elsewhere.
      for (int n = 0; n < 60; n++) begin
         logic [10:0] op;
         int k = int'($urandom_range(0, 7));
         int wf = int'($urandom_range(0, 3));
         int wm = int'($urandom_range(0, 3));
         int cls;
         case (k)
            0: op = 11'b10001011000;
            1: op = 11'b11001011000;
            2: op = 11'b10001010000;
            3: op = 11'b10101010000;
            4: op = 11'b11111000010;
            5: op = 11'b11111000000;
            6: op = {8'b10110100, 3'($urandom)};
            default: op = {6'b000101, 5'($urandom)};
         endcase
         cls = classify(op);
         run_instr("rand", op, rnd(), wf, wm,
                   base_lat(cls) + wf + ((cls == 2 || cls == 3) ? wm : 0));
      end

      run_instr("rand_ill", 11'b01111111111, 1'b0, 1, 0, 0);
      run_instr("final_add", 11'b10001011000, 1'b0, 0, 0, 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
